// File: rtl/led_code_sequencer.sv
// Round-robin sharing of one status LED among several blink-code requesters.
// Winner's code plays as N on/off blinks followed by a dark gap, then done pulses.
`timescale 1ns/1ps
module led_code_sequencer #(
    parameter int NUM_REQ     = 4,
    parameter int CODE_W      = 4,
    parameter int HALF_PERIOD = 1000,
    parameter int GAP_PHASES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*CODE_W-1:0] code,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      done,
    output logic                      led
);

    localparam int GAP_LEN = GAP_PHASES * HALF_PERIOD;
    localparam int TMAX    = (GAP_LEN > HALF_PERIOD) ? GAP_LEN : HALF_PERIOD;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int PW      = $clog2(NUM_REQ);

    localparam logic [TW-1:0] HP_END  = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] GAP_END = TW'(GAP_LEN - 1);
    localparam logic [PW-1:0] LAST    = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [TW-1:0]       r_tmr;
    logic [CODE_W-1:0]   r_cnt;
    logic [PW-1:0]       r_rr;
    logic [PW-1:0]       r_win;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_busy;
    logic                r_done;
    logic                r_led;

    logic                w_any;
    logic [PW-1:0]       w_win;
    logic [CODE_W-1:0]   w_code;

    // Scan downward so the requester closest to r_rr is assigned last and wins.
    always_comb begin
        w_any = |req;
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(r_rr) + k) % NUM_REQ]) begin
                w_win = PW'((int'(r_rr) + k) % NUM_REQ);
            end
        end
    end

    assign w_code = code[w_win*CODE_W +: CODE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_cnt   <= '0;
            r_rr    <= '0;
            r_win   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= NUM_REQ'(1) << w_win;
                        r_busy  <= 1'b1;
                        r_win   <= w_win;
                        r_cnt   <= w_code;
                        r_tmr   <= '0;
                        if (w_code != '0) begin
                            r_state <= S_ON;
                            r_led   <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_ON: begin
                    if (r_tmr == HP_END) begin
                        r_tmr   <= '0;
                        r_led   <= 1'b0;
                        r_state <= S_OFF;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                S_OFF: begin
                    if (r_tmr == HP_END) begin
                        r_tmr <= '0;
                        r_cnt <= r_cnt - CODE_W'(1);
                        if (r_cnt == CODE_W'(1)) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_ON;
                            r_led   <= 1'b1;
                        end
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                S_GAP: begin
                    if (r_tmr == GAP_END) begin
                        r_tmr   <= '0;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_rr    <= (r_win == LAST) ? '0 : r_win + PW'(1);
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;
    assign done  = r_done;
    assign led   = r_led;

endmodule
